id_ex_stage: RTL and testbench

Decode-and-latch stage between the IF/ID register and the execute stage of the MIPS-subset pipeline. Decodes the opcode of the instruction in ID into main control signals, including the 2-bit ALU op consumed with the funct field by the ALU control decoder in EX. Registers all fields into the ID/EX pipeline register. Detects load-use hazards, requests an upstream stall, and supports external hold and flush.

---
 rtl/id_ex_stage.sv | 129 ++++++++++++
 tb/tb_id_ex_stage.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// ID/EX pipeline stage: main-control decode, ID/EX register, load-use hazard detection, hold and flush.
// Optional bubble counter output enabled by defining IDEX_BUBBLE_CNT_EN.
module id_ex_stage #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          id_valid,
  input  logic [31:0]   id_instr,
  input  logic [DW-1:0] id_pc4,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic          stall,
  input  logic          flush,
  output logic          hz_stall,
  output logic          ex_valid,
  output logic [1:0]    ex_aluop,
  output logic [5:0]    ex_func,
  output logic          ex_regdst,
  output logic          ex_alusrc,
  output logic          ex_memread,
  output logic          ex_memwrite,
  output logic          ex_regwrite,
  output logic          ex_memtoreg,
  output logic          ex_branch,
  output logic          ex_illegal,
  output logic [4:0]    ex_rs,
  output logic [4:0]    ex_rt,
  output logic [4:0]    ex_rd,
  output logic [DW-1:0] ex_rs_data,
  output logic [DW-1:0] ex_rt_data,
  output logic [DW-1:0] ex_imm,
  output logic [DW-1:0] ex_pc4
`ifdef IDEX_BUBBLE_CNT_EN
  ,
  output logic [15:0]   bubble_cnt
`endif
);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  logic [5:0]    opcode;
  logic [4:0]    id_rs;
  logic [4:0]    id_rt;
  logic [1:0]    dec_aluop;
  logic [6:0]    dec_ctrl;
  logic          dec_illegal;
  logic          uses_rt;
  logic          hz_raw;
  logic          load_bubble;
  logic [6:0]    ex_ctrl;
  logic [DW-1:0] id_imm;

  assign opcode = id_instr[31:26];
  assign id_rs  = id_instr[25:21];
  assign id_rt  = id_instr[20:16];
  assign id_imm = {{(DW-16){id_instr[15]}}, id_instr[15:0]};

  // Control vector order: regdst, alusrc, memread, memwrite, regwrite, memtoreg, branch
  always_comb begin
    dec_aluop   = 2'b00;
    dec_ctrl    = 7'b0000000;
    dec_illegal = 1'b0;
    uses_rt     = 1'b0;
    case (opcode)
      OP_RTYPE: begin dec_aluop = 2'b10; dec_ctrl = 7'b1000100; uses_rt = 1'b1; end
      OP_LW:    begin dec_aluop = 2'b00; dec_ctrl = 7'b0110110; end
      OP_SW:    begin dec_aluop = 2'b00; dec_ctrl = 7'b0101000; uses_rt = 1'b1; end
      OP_BEQ:   begin dec_aluop = 2'b01; dec_ctrl = 7'b0000001; uses_rt = 1'b1; end
      OP_ADDI:  begin dec_aluop = 2'b00; dec_ctrl = 7'b0100100; end
      default:  dec_illegal = 1'b1;
    endcase
  end

  // rt is only a source operand for R-type, sw and beq; for lw/addi it is the destination
  assign hz_raw = ex_valid & ex_memread & id_valid & (ex_rt != 5'd0) &
                  ((ex_rt == id_rs) | (uses_rt & (ex_rt == id_rt)));
  assign hz_stall    = hz_raw & ~stall & ~reset;
  assign load_bubble = flush | hz_stall | ~id_valid;

  assign {ex_regdst, ex_alusrc, ex_memread, ex_memwrite,
          ex_regwrite, ex_memtoreg, ex_branch} = ex_ctrl;

  // Flush overrides the external hold; otherwise stall freezes the register
  always_ff @(posedge clk) begin
    if (reset || ((flush || !stall) && load_bubble)) begin
      ex_valid   <= 1'b0;
      ex_aluop   <= 2'b00;
      ex_func    <= '0;
      ex_ctrl    <= '0;
      ex_illegal <= 1'b0;
      ex_rs      <= '0;
      ex_rt      <= '0;
      ex_rd      <= '0;
      ex_rs_data <= '0;
      ex_rt_data <= '0;
      ex_imm     <= '0;
      ex_pc4     <= '0;
    end else if (!stall) begin
      ex_valid   <= 1'b1;
      ex_aluop   <= dec_aluop;
      ex_func    <= id_instr[5:0];
      ex_ctrl    <= dec_ctrl;
      ex_illegal <= dec_illegal;
      ex_rs      <= id_rs;
      ex_rt      <= id_rt;
      ex_rd      <= id_instr[15:11];
      ex_rs_data <= id_rs_data;
      ex_rt_data <= id_rt_data;
      ex_imm     <= id_imm;
      ex_pc4     <= id_pc4;
    end
  end

`ifdef IDEX_BUBBLE_CNT_EN
  // Counts only hazard- and flush-induced bubbles, not idle (invalid) slots
  always_ff @(posedge clk) begin
    if (reset)
      bubble_cnt <= '0;
    else if (flush || hz_stall)
      bubble_cnt <= bubble_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: decode vector table plus hazard, hold, flush and reset sequences.
// Counter checks are compiled in when IDEX_BUBBLE_CNT_EN is defined.
module tb_id_ex_stage;

  typedef struct packed {
    logic        valid;
    logic [1:0]  aluop;
    logic [5:0]  func;
    logic [6:0]  ctrl;
    logic        illegal;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] imm;
    logic [31:0] pc4;
  } exp_t;

  typedef struct {
    logic        valid;
    logic [31:0] instr;
    logic [31:0] rs_data;
    logic [31:0] rt_data;
    logic [31:0] pc4;
    exp_t        exp;
  } vec_t;

  localparam logic [31:0] LW8    = 32'h8C280000;
  localparam logic [31:0] ADD_D  = 32'h01014820;
  localparam logic [31:0] SW_D   = 32'hAC480000;
  localparam logic [31:0] ADDI_N = 32'h20480001;
  localparam logic [31:0] LW0    = 32'h8C200000;
  localparam logic [31:0] ADD_Z  = 32'h00004820;
  localparam logic [31:0] D_RS   = 32'h00000011;
  localparam logic [31:0] D_RT   = 32'h00000022;
  localparam logic [31:0] D_PC   = 32'h00000100;

  logic        clk = 1'b0;
  logic        reset;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc4;
  logic [31:0] id_rs_data;
  logic [31:0] id_rt_data;
  logic        stall;
  logic        flush;
  logic        hz_stall;
  logic        ex_valid;
  logic [1:0]  ex_aluop;
  logic [5:0]  ex_func;
  logic        ex_regdst, ex_alusrc, ex_memread, ex_memwrite;
  logic        ex_regwrite, ex_memtoreg, ex_branch, ex_illegal;
  logic [4:0]  ex_rs, ex_rt, ex_rd;
  logic [31:0] ex_rs_data, ex_rt_data, ex_imm, ex_pc4;
`ifdef IDEX_BUBBLE_CNT_EN
  logic [15:0] bubble_cnt;
`endif

  exp_t        act;
  exp_t        sb[$];
  exp_t        last_out;
  vec_t        vecs[7];
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.DW(32)) dut (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_instr(id_instr),
    .id_pc4(id_pc4), .id_rs_data(id_rs_data), .id_rt_data(id_rt_data),
    .stall(stall), .flush(flush), .hz_stall(hz_stall),
    .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_func(ex_func),
    .ex_regdst(ex_regdst), .ex_alusrc(ex_alusrc), .ex_memread(ex_memread),
    .ex_memwrite(ex_memwrite), .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg),
    .ex_branch(ex_branch), .ex_illegal(ex_illegal),
    .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
    .ex_rs_data(ex_rs_data), .ex_rt_data(ex_rt_data), .ex_imm(ex_imm), .ex_pc4(ex_pc4)
`ifdef IDEX_BUBBLE_CNT_EN
    , .bubble_cnt(bubble_cnt)
`endif
  );

  assign act = {ex_valid, ex_aluop, ex_func,
                ex_regdst, ex_alusrc, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg, ex_branch,
                ex_illegal, ex_rs, ex_rt, ex_rd, ex_rs_data, ex_rt_data, ex_imm, ex_pc4};

  function automatic exp_t mk_exp(input logic [1:0] aluop, input logic [6:0] ctrl,
                                  input logic illegal, input logic [31:0] instr,
                                  input logic [31:0] rsd, input logic [31:0] rtd,
                                  input logic [31:0] imm, input logic [31:0] pc4);
    exp_t e;
    e.valid   = 1'b1;
    e.aluop   = aluop;
    e.func    = instr[5:0];
    e.ctrl    = ctrl;
    e.illegal = illegal;
    e.rs      = instr[25:21];
    e.rt      = instr[20:16];
    e.rd      = instr[15:11];
    e.rs_data = rsd;
    e.rt_data = rtd;
    e.imm     = imm;
    e.pc4     = pc4;
    return e;
  endfunction

  task automatic check(input string name, input logic [159:0] got, input logic [159:0] want);
    checks++;
    if (got === want) passes++;
    else $display("[TB] FAIL %s: got %h expected %h", name, got, want);
  endtask

  // Drive one ID slot, check the combinational stall request, queue the expected EX contents
  task automatic applyStimulus(input logic v, input logic [31:0] instr, input logic [31:0] rsd,
                               input logic [31:0] rtd, input logic [31:0] pc4,
                               input logic st, input logic fl, input logic exp_hz,
                               input exp_t e, input string name);
    id_valid   = v;
    id_instr   = instr;
    id_rs_data = rsd;
    id_rt_data = rtd;
    id_pc4     = pc4;
    stall      = st;
    flush      = fl;
    #1;
    check({name, " hz_stall"}, {159'd0, hz_stall}, {159'd0, exp_hz});
    sb.push_back(e);
  endtask

  task automatic checkOutput(input string name);
    exp_t e;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++;
      $display("[TB] FAIL %s: scoreboard empty, got %h expected an entry", name, act);
    end else begin
      e = sb.pop_front();
      check(name, act, e);
      last_out = e;
    end
  endtask

  task automatic cycle(input logic [31:0] instr, input logic st, input logic fl,
                       input logic exp_hz, input exp_t e, input string name);
    applyStimulus(1'b1, instr, D_RS, D_RT, D_PC, st, fl, exp_hz, e, name);
    checkOutput(name);
  endtask

  exp_t e_lw8, e_add, e_sw, e_addi, e_lw0, e_addz;

  initial begin
    e_lw8  = mk_exp(2'b00, 7'b0110110, 1'b0, LW8,    D_RS, D_RT, 32'h00000000, D_PC);
    e_add  = mk_exp(2'b10, 7'b1000100, 1'b0, ADD_D,  D_RS, D_RT, 32'h00004820, D_PC);
    e_sw   = mk_exp(2'b00, 7'b0101000, 1'b0, SW_D,   D_RS, D_RT, 32'h00000000, D_PC);
    e_addi = mk_exp(2'b00, 7'b0100100, 1'b0, ADDI_N, D_RS, D_RT, 32'h00000001, D_PC);
    e_lw0  = mk_exp(2'b00, 7'b0110110, 1'b0, LW0,    D_RS, D_RT, 32'h00000000, D_PC);
    e_addz = mk_exp(2'b10, 7'b1000100, 1'b0, ADD_Z,  D_RS, D_RT, 32'h00004820, D_PC);

    vecs[0] = '{1'b1, 32'h00221820, 32'hA0000000, 32'hB0000000, 32'h00400004,
                mk_exp(2'b10, 7'b1000100, 1'b0, 32'h00221820, 32'hA0000000, 32'hB0000000, 32'h00001820, 32'h00400004)};
    vecs[1] = '{1'b1, 32'h8CA4FFFC, 32'hA0000001, 32'hB0000001, 32'h00400008,
                mk_exp(2'b00, 7'b0110110, 1'b0, 32'h8CA4FFFC, 32'hA0000001, 32'hB0000001, 32'hFFFFFFFC, 32'h00400008)};
    vecs[2] = '{1'b1, 32'hACE60008, 32'hA0000002, 32'hB0000002, 32'h0040000C,
                mk_exp(2'b00, 7'b0101000, 1'b0, 32'hACE60008, 32'hA0000002, 32'hB0000002, 32'h00000008, 32'h0040000C)};
    vecs[3] = '{1'b1, 32'h1109FFFF, 32'hA0000003, 32'hB0000003, 32'h00400010,
                mk_exp(2'b01, 7'b0000001, 1'b0, 32'h1109FFFF, 32'hA0000003, 32'hB0000003, 32'hFFFFFFFF, 32'h00400010)};
    vecs[4] = '{1'b1, 32'h216A7FFF, 32'hA0000004, 32'hB0000004, 32'h00400014,
                mk_exp(2'b00, 7'b0100100, 1'b0, 32'h216A7FFF, 32'hA0000004, 32'hB0000004, 32'h00007FFF, 32'h00400014)};
    vecs[5] = '{1'b1, 32'hFC221820, 32'hA0000005, 32'hB0000005, 32'h00400018,
                mk_exp(2'b00, 7'b0000000, 1'b1, 32'hFC221820, 32'hA0000005, 32'hB0000005, 32'h00001820, 32'h00400018)};
    vecs[6] = '{1'b0, 32'h00221820, 32'hA0000006, 32'hB0000006, 32'h0040001C, '0};

    // Reset with random inputs
    reset = 1'b1;
    @(posedge clk); #1;
    for (int i = 0; i < 2; i++)
      applyStimulus($urandom_range(0, 1), $urandom, $urandom, $urandom, $urandom,
                    $urandom_range(0, 1), $urandom_range(0, 1), 1'b0, '0, "reset");
    // Both queued entries are checked after consecutive reset edges
    checkOutput("reset0");
    checkOutput("reset1");
    reset = 1'b0;

    // Decode table
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].valid, vecs[i].instr, vecs[i].rs_data, vecs[i].rt_data,
                    vecs[i].pc4, 1'b0, 1'b0, 1'b0, vecs[i].exp, $sformatf("decode%0d", i));
      checkOutput($sformatf("decode%0d", i));
    end

    // Load-use on rs: one bubble, then the held add loads
    cycle(LW8,   1'b0, 1'b0, 1'b0, e_lw8, "lu_lw");
    cycle(ADD_D, 1'b0, 1'b0, 1'b1, '0,    "lu_bubble");
    cycle(ADD_D, 1'b0, 1'b0, 1'b0, e_add, "lu_add");
    // Load-use on rt of a store
    cycle(LW8,   1'b0, 1'b0, 1'b0, e_lw8, "sw_lw");
    cycle(SW_D,  1'b0, 1'b0, 1'b1, '0,    "sw_bubble");
    cycle(SW_D,  1'b0, 1'b0, 1'b0, e_sw,  "sw_load");
    // addi writes rt, so matching rt is not a hazard
    cycle(LW8,    1'b0, 1'b0, 1'b0, e_lw8,  "addi_lw");
    cycle(ADDI_N, 1'b0, 1'b0, 1'b0, e_addi, "addi_nohz");
    // Load into $0 never stalls
    cycle(LW0,   1'b0, 1'b0, 1'b0, e_lw0,  "z_lw");
    cycle(ADD_Z, 1'b0, 1'b0, 1'b0, e_addz, "z_add");

    // External hold for 3 cycles freezes outputs
    cycle(ADD_D, 1'b0, 1'b0, 1'b0, e_add, "hold_load");
    for (int i = 0; i < 3; i++)
      cycle(LW8, 1'b1, 1'b0, 1'b0, last_out, $sformatf("hold%0d", i));
    cycle(LW8, 1'b1, 1'b1, 1'b0, '0, "stall_flush");

    // Stall masks hz_stall; releasing it exposes the hazard
    cycle(LW8,   1'b0, 1'b0, 1'b0, e_lw8, "mask_lw");
    cycle(ADD_D, 1'b1, 1'b0, 1'b0, e_lw8, "mask_hold");
    cycle(ADD_D, 1'b0, 1'b0, 1'b1, '0,    "mask_bubble");

    // Flush during a load-use hazard
    cycle(LW8,   1'b0, 1'b0, 1'b0, e_lw8, "fhz_lw");
    cycle(ADD_D, 1'b0, 1'b1, 1'b1, '0,    "fhz_bubble");

    // Reset mid-stall with a pending hazard
    cycle(LW8, 1'b0, 1'b0, 1'b0, e_lw8, "rst_lw");
    reset = 1'b1;
    cycle(ADD_D, 1'b1, 1'b0, 1'b0, '0, "rst_mid");
    reset = 1'b0;

`ifdef IDEX_BUBBLE_CNT_EN
    reset = 1'b1;
    cycle(ADD_D, 1'b0, 1'b0, 1'b0, '0, "cnt_rst");
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cycle(LW8,   1'b0, 1'b0, 1'b0, e_lw8, "cnt_lw");
      cycle(ADD_D, 1'b0, 1'b0, 1'b1, '0,    "cnt_bubble");
      cycle(ADD_D, 1'b0, 1'b0, 1'b0, e_add, "cnt_add");
    end
    cycle(ADD_D, 1'b0, 1'b1, 1'b0, '0, "cnt_flush0");
    cycle(ADD_D, 1'b1, 1'b0, 1'b0, '0, "cnt_hold");
    cycle(ADD_D, 1'b0, 1'b1, 1'b0, '0, "cnt_flush1");
    check("bubble_cnt5", {144'd0, bubble_cnt}, {144'd0, 16'd5});
    flush = 1'b1;
    for (int i = 0; i < 65530; i++) @(posedge clk);
    #1;
    check("bubble_cnt_max", {144'd0, bubble_cnt}, {144'd0, 16'hFFFF});
    @(posedge clk); #1;
    check("bubble_cnt_wrap", {144'd0, bubble_cnt}, {144'd0, 16'h0000});
    flush = 1'b0;
`endif

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
